// File: rtl/ram_pkg.sv
// Shared definitions for the byte-lane RAM bank: controller states and lane width.
package ram_pkg;

    localparam int unsigned LANE_W = 8;

    typedef enum logic {
        CLEAR,
        READY
    } state_t;

endpackage

// File: rtl/ram_core.sv
// Single-port synchronous memory with per-byte write enables and a registered read.
module ram_core
    import ram_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = 8,
    parameter int unsigned WIDTH      = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic                    re,
    input  logic [ADDR_WIDTH-1:0]   addr,
    input  logic [WIDTH-1:0]        wdata,
    input  logic [WIDTH/LANE_W-1:0] be,
    output logic [WIDTH-1:0]        rdata
);

    localparam int unsigned DEPTH = 2 ** ADDR_WIDTH;
    localparam int unsigned LANES = WIDTH / LANE_W;

    logic [WIDTH-1:0] mem [DEPTH];

    // The array itself is never reset; only the sweep initialises it.
    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (be[i]) begin
                    mem[addr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
                end
            end
        end
    end

    // Holds the last read word until the next read.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/ram_bank.sv
// RAM bank controller: clear sweep FSM, request acceptance and read response valid.
module ram_bank
    import ram_pkg::*;
#(
    parameter int unsigned      ADDR_WIDTH     = 8,
    parameter int unsigned      WIDTH          = 16,
    parameter bit               CLEAR_ON_RESET = 1'b1,
    parameter logic [WIDTH-1:0] CLR_VALUE      = '0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic                    req_we,
    input  logic [ADDR_WIDTH-1:0]   req_addr,
    input  logic [WIDTH-1:0]        req_wdata,
    input  logic [WIDTH/LANE_W-1:0] req_be,
    input  logic                    clr_start,
    output logic                    rsp_valid,
    output logic [WIDTH-1:0]        rsp_rdata,
    output logic                    busy
);

    localparam int unsigned LANES = WIDTH / LANE_W;

    state_t                  state, state_nx;
    logic [ADDR_WIDTH-1:0]   clr_ptr, clr_ptr_nx;
    logic                    accept;
    logic                    mem_we, mem_re;
    logic [ADDR_WIDTH-1:0]   mem_addr;
    logic [WIDTH-1:0]        mem_wdata;
    logic [LANES-1:0]        mem_be;

    // Ready is also gated by reset so no request is taken while rst_n is low.
    assign req_ready = rst_n && (state == READY);
    assign busy      = (state == CLEAR);
    assign accept    = req_valid && req_ready;

    always_comb begin
        state_nx   = state;
        clr_ptr_nx = clr_ptr;
        mem_we     = 1'b0;
        mem_re     = 1'b0;
        mem_addr   = req_addr;
        mem_wdata  = req_wdata;
        mem_be     = req_be;
        unique case (state)
            CLEAR: begin
                mem_we    = rst_n;
                mem_addr  = clr_ptr;
                mem_wdata = CLR_VALUE;
                mem_be    = '1;
                if (clr_ptr == '1) begin
                    state_nx   = READY;
                    clr_ptr_nx = '0;
                end else begin
                    clr_ptr_nx = clr_ptr + 1'b1;
                end
            end
            READY: begin
                mem_we = accept && req_we;
                mem_re = accept && !req_we;
                if (clr_start) begin
                    state_nx   = CLEAR;
                    clr_ptr_nx = '0;
                end
            end
            default: state_nx = READY;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= CLEAR_ON_RESET ? CLEAR : READY;
            clr_ptr   <= '0;
            rsp_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            clr_ptr   <= clr_ptr_nx;
            rsp_valid <= mem_re;
        end
    end

    ram_core #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .WIDTH      (WIDTH)
    ) u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (mem_we),
        .re    (mem_re),
        .addr  (mem_addr),
        .wdata (mem_wdata),
        .be    (mem_be),
        .rdata (rsp_rdata)
    );

endmodule

// File: doc/ram_bank.md
RAM_BANK -- requirements
Module: ram_bank

Interface
REQ-001 The block SHALL have parameter ADDR_WIDTH, default 8, meaning address bits; depth DEPTH = 2**ADDR_WIDTH words.
REQ-002 The block SHALL have parameter WIDTH, default 16, meaning data word bits; it must be a multiple of 8, and LANES = WIDTH/8.
REQ-003 The block SHALL have parameter CLEAR_ON_RESET, default 1, meaning a hardware clear sweep runs after reset.
REQ-004 The block SHALL have parameter CLR_VALUE, default 0 (WIDTH bits), meaning the word written by the clear sweep.
REQ-005 Port clk SHALL be an input, 1 bit wide: the single clock; all logic is on its rising edge.
REQ-006 Port rst_n SHALL be an input, 1 bit wide: reset, synchronous and active-low.
REQ-007 Port req_valid SHALL be an input, 1 bit wide: a request is present.
REQ-008 Port req_ready SHALL be an output, 1 bit wide: the request is accepted this cycle.
REQ-009 Port req_we SHALL be an input, 1 bit wide: 1 = write, 0 = read.
REQ-010 Port req_addr SHALL be an input, ADDR_WIDTH bits wide: the word address.
REQ-011 Port req_wdata SHALL be an input, WIDTH bits wide: the write data.
REQ-012 Port req_be SHALL be an input, LANES bits wide: per-byte write enables; bit i covers data bits [8i+7:8i].
REQ-013 Port clr_start SHALL be an input, 1 bit wide: a single-cycle pulse that starts a clear sweep.
REQ-014 Port rsp_valid SHALL be an output, 1 bit wide: read data is valid, as a one-cycle pulse.
REQ-015 Port rsp_rdata SHALL be an output, WIDTH bits wide: the read data.
REQ-016 Port busy SHALL be an output, 1 bit wide: a clear sweep is in progress.

Function
REQ-017 The FSM SHALL have two states. CLEAR: writes CLR_VALUE to addr clr_ptr, increments clr_ptr, and moves to READY after writing DEPTH-1. READY: serves requests.
REQ-018 A request SHALL be accepted when req_valid && req_ready; req_ready = 1 only in READY.
REQ-019 An accepted write SHALL update only the lanes with req_be[i]=1; other lanes keep their value. req_be=0 SHALL still be accepted, as a no-op.
REQ-020 An accepted write SHALL produce no response; rsp_valid stays 0 on the next cycle.
REQ-021 An accepted read SHALL drive rsp_valid=1 and rsp_rdata=mem[addr] exactly 1 cycle later (latency 1).
REQ-022 rsp_rdata SHALL hold its last read value until the next read response.
REQ-023 There SHALL be no response backpressure.
REQ-024 Back-to-back reads SHALL give full throughput: one response per cycle, in order.
REQ-025 A read at address A on the cycle immediately after a write to A SHALL return the new data.
REQ-026 clr_start in READY SHALL start a sweep: the next cycle is CLEAR, clr_ptr=0, and busy=1.
REQ-027 clr_start in CLEAR SHALL be ignored; the sweep does not restart.
REQ-028 If clr_start and an accepted request occur in the same READY cycle, the request SHALL complete (a read still responds next cycle) and CLEAR SHALL begin the next cycle.
REQ-029 A sweep SHALL take exactly DEPTH cycles; busy is high for exactly those cycles.
REQ-030 A read response already in flight when a sweep starts SHALL still be delivered.
REQ-031 clr_ptr SHALL be ADDR_WIDTH bits wide and SHALL NOT wrap back into CLEAR; the final address DEPTH-1 ends the sweep.

Reset
REQ-032 While rst_n=0 at a clock edge: req_ready=0, rsp_valid=0, rsp_rdata=0, clr_ptr=0.
REQ-033 While rst_n=0: state=CLEAR and busy=1 if CLEAR_ON_RESET=1; otherwise state=READY and busy=0.
REQ-034 Memory contents SHALL NOT be reset directly; they are initialised only by the sweep.
REQ-035 Reset asserted mid-sweep SHALL restart the sweep from address 0 (when CLEAR_ON_RESET=1).
REQ-036 Reset asserted mid-read SHALL drop the pending response.

Structure
REQ-037 Package ram_pkg SHALL hold the state enum (CLEAR, READY) and a LANE_W=8 constant.
REQ-038 Sub-module ram_core SHALL hold the byte-lane-enabled synchronous memory array (one write port, one registered read).
REQ-039 ram_bank SHALL hold the FSM, the clear pointer, arbitration and the response valid.

Verification (ADDR_WIDTH=4, WIDTH=16)
REQ-040 Release reset -> busy=1 and req_ready=0 for 16 cycles, then READY; reads of addrs 0..15 all return 0x0000.
REQ-041 Write addr 3 = 0xBEEF, be=11, then read 3 -> rsp_valid exactly 1 cycle after acceptance, rdata=0xBEEF.
REQ-042 Write addr 3 = 0x1234, be=01, then read 3 -> 0xBE34.
REQ-043 Write addr 5 = 0xAAAA, then read 5 on the immediately following cycle -> 0xAAAA.
REQ-044 Reads at 5,3,5 on consecutive cycles -> 3 consecutive rsp_valid pulses: 0xAAAA, 0xBE34, 0xAAAA.
REQ-045 Pulse clr_start with a read of addr 5 in the same cycle -> response 0xAAAA on the next cycle, busy high 16 cycles; rst_n low at sweep cycle 7 -> sweep restarts, busy high 16 more cycles; all words then read 0.
